// File: rtl/word_bank_splitter_pkg.sv
// Shared definitions for the word bank splitter: FSM encoding, bank-select
// constants and default geometry.
package word_bank_splitter_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_WORDS = 16;

    localparam logic F32_BANK = 1'b0;
    localparam logic S32_BANK = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/word_bank_splitter_if.sv
// Serial word input bus with bank select.
// Handshake: a word transfers on a rising clk edge where in_valid = 1 and
// in_ready = 1; the producer keeps in_data/in_valid stable until that edge,
// and in_ready depends only on the consumer's state, never on in_valid.
interface word_bank_splitter_if
    import word_bank_splitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             sel;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    modport master (
        output sel,
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  sel,
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/word_bank_splitter_bank_regfile.sv
// One bank: WORDS x WIDTH register array with a single indexed write port
// and the whole array exposed as a flat vector (word k at [k*WIDTH +: WIDTH]).
module bank_regfile
    import word_bank_splitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WORDS = DEFAULT_WORDS,
    parameter int IW    = $clog2(WORDS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [IW-1:0]          idx,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH*WORDS-1:0] bank
);

    logic [WORDS-1:0][WIDTH-1:0] mem;

    assign bank = mem;

    // Write only the addressed word; every other word holds its contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '0;
        end else if (we) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/word_bank_splitter.sv
// Collects a burst of WORDS serial words into one of two banks (f32 / s32),
// chosen by sel at the first word of the burst. A one-cycle DONE state
// closes each burst with a done pulse and sets the bank's sticky full flag.
module word_bank_splitter
    import word_bank_splitter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic                   clk,
    input  logic                   rst,
    word_bank_splitter_if.slave    bus,
    output logic [WIDTH*WORDS-1:0] f32_bank,
    output logic [WIDTH*WORDS-1:0] s32_bank,
    output logic                   f32_full,
    output logic                   s32_full,
    output logic                   done,
    output logic                   done_bank,
    output state_t                 state
);

    localparam int CW = $clog2(WORDS);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    state_t        state_q;
    logic [CW-1:0] count;
    logic          bank_q;

    logic          accept;
    logic          wr_bank;
    logic [CW-1:0] wr_idx;
    logic          f32_we;
    logic          s32_we;

    // Ready is withheld only in DONE and while reset is held.
    assign bus.in_ready = !rst && (state_q != DONE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign state        = state_q;

    // The first word of a burst is steered by the live sel; later words by
    // the latched bank so sel changes mid-burst have no effect.
    assign wr_bank = (state_q == IDLE) ? bus.sel : bank_q;
    assign wr_idx  = (state_q == IDLE) ? '0 : count;
    assign f32_we  = accept && (wr_bank == F32_BANK);
    assign s32_we  = accept && (wr_bank == S32_BANK);

    // Burst sequencing, done pulse and sticky full flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count     <= '0;
            bank_q    <= F32_BANK;
            done      <= 1'b0;
            done_bank <= 1'b0;
            f32_full  <= 1'b0;
            s32_full  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        bank_q  <= bus.sel;
                        count   <= CW'(1);
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        count <= count + CW'(1);
                        if (count == LAST) begin
                            state_q   <= DONE;
                            done      <= 1'b1;
                            done_bank <= bank_q;
                            if (bank_q == F32_BANK) begin
                                f32_full <= 1'b1;
                            end else begin
                                s32_full <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    bank_regfile #(.WIDTH(WIDTH), .WORDS(WORDS), .IW(CW)) u_f32_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (f32_we),
        .idx   (wr_idx),
        .wdata (bus.in_data),
        .bank  (f32_bank)
    );

    bank_regfile #(.WIDTH(WIDTH), .WORDS(WORDS), .IW(CW)) u_s32_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (s32_we),
        .idx   (wr_idx),
        .wdata (bus.in_data),
        .bank  (s32_bank)
    );

endmodule

// File: doc/word_bank_splitter.md
WORD_BANK_SPLITTER -- requirements
Module: word_bank_splitter

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one data word.
REQ-002 Parameter WORDS, default 16, words per bank; must be a power of two, 2..64.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sel  input  1  bank select: 0 = f32 bank, 1 = s32 bank; sampled only when a burst's first word is accepted.
REQ-006 in_valid  input  1  producer has a word on in_data.
REQ-007 in_data  input  WIDTH  incoming serial word.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 f32_bank  output  WIDTH*WORDS  f32 bank, flat; word k at bits [k*WIDTH +: WIDTH].
REQ-010 s32_bank  output  WIDTH*WORDS  s32 bank, same packing as f32_bank.
REQ-011 f32_full  output  1  f32 bank holds a complete burst since reset.
REQ-012 s32_full  output  1  s32 bank holds a complete burst since reset.
REQ-013 done  output  1  one-cycle pulse when a burst completes.
REQ-014 done_bank  output  1  bank just completed; valid only while done = 1.

Function
REQ-015 Transfer rule: a word is accepted when in_valid = 1 and in_ready = 1 on a rising edge.
REQ-016 FSM states: IDLE, LOAD, DONE; reset state is IDLE.
REQ-017 IDLE: in_ready = 1; on accept, latch sel into bank_q, write the word to index 0 of that bank, set count = 1, go to LOAD.
REQ-018 LOAD: in_ready = 1; on accept, write the word to index count of bank_q and increment count.
REQ-019 LOAD to DONE on the accept where count = WORDS-1; count then wraps to 0.
REQ-020 DONE lasts exactly one cycle: in_ready = 0, done = 1, done_bank = bank_q; then go to IDLE.
REQ-021 On entry to DONE, the flag for bank_q (f32_full or s32_full) becomes 1 and stays 1 until reset.
REQ-022 A new burst may start in the cycle after DONE; back-to-back bursts sustain WORDS accepts per WORDS+1 cycles.
REQ-023 Changes on sel after the first accept are ignored until the next burst.
REQ-024 in_valid = 0 in LOAD stalls the block: count, data and state hold.
REQ-025 Only the addressed word of bank_q is written; the other bank is never touched during the burst.
REQ-026 Bank words are registered and appear on the outputs the cycle after their accept.
REQ-027 A partially loaded bank shows the new words at the written indices and the old contents elsewhere; its full flag keeps its prior value.
REQ-028 in_data is not checked or modified: plain WIDTH-bit copy, no sign or format handling.

Reset
REQ-029 While rst = 1, asynchronously: state = IDLE, count = 0, bank_q = 0, all bank words = 0, f32_full = s32_full = 0, done = 0, done_bank = 0.
REQ-030 in_ready is 0 while rst = 1 and 1 in the first cycle after deassertion.
REQ-031 Reset during LOAD or DONE discards the partial burst; no done pulse is produced for it.

Structure
REQ-032 Shared package holds the state encoding (IDLE/LOAD/DONE), the bank-select constants F32_BANK = 0 and S32_BANK = 1, and the defaults WIDTH = 32 and WORDS = 16.
REQ-033 One sub-module, bank_regfile: WORDS x WIDTH register array with write enable and index, flat output; instantiated twice, once per bank.
REQ-034 The count width is log2(WORDS); no other counters.

Verification
REQ-035 Reset, then sel = 0 and 16 continuous words 0x1000..0x100F -> f32 word k = 0x1000+k, s32_bank all 0, done pulse with done_bank = 0 one cycle after the 16th accept, f32_full = 1.
REQ-036 sel = 1 burst 0xA0..0xAF with in_valid low for 3 cycles after word 5 -> count holds during the gap, s32 word k = 0xA0+k, done_bank = 1, f32 contents unchanged.
REQ-037 sel toggled every cycle during a sel = 0 burst -> all 16 words land in the f32 bank only.
REQ-038 Two back-to-back bursts (sel = 0, then sel = 1), in_valid held high -> in_ready = 0 exactly one cycle between them, two done pulses 17 cycles apart.
REQ-039 rst asserted after 7 words of a sel = 1 burst -> no done pulse, all outputs 0, then a fresh 16-word burst loads from index 0.
REQ-040 Producer that holds in_data stable while in_ready = 0 in DONE -> that word is accepted as index 0 of the next burst, with no duplicate and no loss.
